// File: rtl/match_resp_collector_pkg.sv
// Shared parameters header for the match-response collector slice.
// Holds job-PE geometry, match-length width and the buffered response record.
package match_resp_collector_pkg;

    localparam int unsigned NUM_MATCH_PE_DEFAULT = 4;
    localparam int unsigned NUM_JOB_PE           = 4;
    // The id field is one bit wider than NUM_JOB_PE needs, so out-of-range ids can arrive and be flagged.
    localparam int unsigned NUM_JOB_PE_LOG2      = 3;
    localparam int unsigned MAX_MATCH_LEN_LOG2   = 5;
    localparam int unsigned LW                   = MAX_MATCH_LEN_LOG2 + 1;

    typedef struct packed {
        logic [NUM_JOB_PE_LOG2-1:0] job_pe_id;
        logic [7:0]                 tag;
        logic [LW-1:0]              match_len;
    } resp_t;

endpackage

// File: rtl/match_resp_collector_rr_arbiter.sv
// Round-robin arbiter: searches the request vector starting at an internal pointer and
// grants at most one requester; the pointer moves past the winner when the grant is taken.
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic          accept,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] cand;
    logic          found;

    // N is a power of two, so the IW-bit add wraps the search naturally.
    always_comb begin
        grant     = '0;
        grant_idx = ptr;
        cand      = ptr;
        found     = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = ptr + IW'(i);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        if (found && en) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/match_resp_collector.sv
// Collects responses from the match PEs through a round-robin arbiter into a 2-entry
// in-order buffer and routes the head entry to its destination job PE.
module match_resp_collector
    import match_resp_collector_pkg::*;
#(
    parameter int unsigned NUM_MATCH_PE = NUM_MATCH_PE_DEFAULT
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_MATCH_PE-1:0]               i_match_resp_valid,
    output logic [NUM_MATCH_PE-1:0]               o_match_resp_ready,
    input  logic [NUM_MATCH_PE*NUM_JOB_PE_LOG2-1:0] i_match_resp_job_pe_id,
    input  logic [NUM_MATCH_PE*8-1:0]             i_match_resp_tag,
    input  logic [NUM_MATCH_PE*LW-1:0]            i_match_resp_match_len,
    output logic [NUM_JOB_PE-1:0]                 o_job_resp_valid,
    input  logic [NUM_JOB_PE-1:0]                 i_job_resp_ready,
    output logic [7:0]                            o_job_resp_tag,
    output logic [LW-1:0]                         o_job_resp_match_len,
    output logic                                  o_err_bad_id
);

    localparam int unsigned PW = $clog2(NUM_MATCH_PE);

    logic [NUM_MATCH_PE-1:0] grant;
    logic [PW-1:0]           grant_idx;
    logic                    arb_en;
    logic                    push;
    logic                    pop;
    logic                    nonempty;
    logic                    head_bad;
    logic [1:0]              count;
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic                    err_q;
    int unsigned             sel;
    resp_t                   mem [2];
    resp_t                   in_resp;
    resp_t                   head;

    // Ready is gated by reset directly so no grant is visible while rst_n is low.
    assign arb_en             = rst_n && (count < 2'd2);
    assign o_match_resp_ready = grant;
    assign push               = |(i_match_resp_valid & grant);

    rr_arbiter #(
        .N(NUM_MATCH_PE)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (i_match_resp_valid),
        .en        (arb_en),
        .accept    (push),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign sel = 32'(grant_idx);

    always_comb begin
        in_resp.job_pe_id = i_match_resp_job_pe_id[sel*NUM_JOB_PE_LOG2 +: NUM_JOB_PE_LOG2];
        in_resp.tag       = i_match_resp_tag[sel*8 +: 8];
        in_resp.match_len = i_match_resp_match_len[sel*LW +: LW];
    end

    assign head     = mem[rd_ptr];
    assign nonempty = (count != 2'd0);
    assign head_bad = (32'(head.job_pe_id) >= NUM_JOB_PE);

    always_comb begin
        o_job_resp_valid = '0;
        for (int unsigned j = 0; j < NUM_JOB_PE; j++) begin
            if (nonempty && !head_bad && (32'(head.job_pe_id) == j)) begin
                o_job_resp_valid[j] = 1'b1;
            end
        end
    end

    // A bad-id head is discarded without a handshake; otherwise only the addressed ready counts.
    assign pop = nonempty && (head_bad || |(o_job_resp_valid & i_job_resp_ready));

    assign o_job_resp_tag       = head.tag;
    assign o_job_resp_match_len = head.match_len;
    assign o_err_bad_id         = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (pop && head_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_resp;
        end
    end

endmodule
